// File: rtl/water_ram_ctrl.sv
// Write-port controller for the water bitmap RAM: a full-frame level-fill sweep
// shared with fixed-priority single-pixel writes. All outputs are registered.
module water_ram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2,
    parameter int COL_BITS   = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fill_start,
    input  logic [ADDR_WIDTH-COL_BITS:0]     fill_level,
    input  logic [DATA_WIDTH-1:0]            water_color,
    input  logic [DATA_WIDTH-1:0]            bg_color,
    input  logic                             pw_req,
    input  logic [ADDR_WIDTH-1:0]            pw_addr,
    input  logic [DATA_WIDTH-1:0]            pw_data,
    output logic                             pw_gnt,
    output logic                             we,
    output logic [ADDR_WIDTH-1:0]            addr_w,
    output logic [DATA_WIDTH-1:0]            din,
    output logic                             busy,
    output logic                             fill_done
);
    localparam int RB = ADDR_WIDTH - COL_BITS;
    localparam int LW = RB + 1;
    localparam logic [LW-1:0] ROWS = LW'(2 ** RB);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

    state_e                  state_q, state_d;
    // Extra top bit flags that the last address has been written.
    logic [ADDR_WIDTH:0]     ptr_q, ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [DATA_WIDTH-1:0]   wcol_q, wcol_d, bcol_q, bcol_d;
    logic                    gnt_q, gnt_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    is_water;

    assign is_water = {1'b0, ptr_q[ADDR_WIDTH-1:COL_BITS]} >= (ROWS - level_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        level_d = level_q;
        wcol_d  = wcol_q;
        bcol_d  = bcol_q;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        gnt_d   = pw_req && !gnt_q;
        we_d    = gnt_d;
        if (gnt_d) begin
            addr_d = pw_addr;
            din_d  = pw_data;
        end
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    level_d = (fill_level > ROWS) ? ROWS : fill_level;
                    wcol_d  = water_color;
                    bcol_d  = bg_color;
                    ptr_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (ptr_q[ADDR_WIDTH]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!gnt_d) begin
                    // A grant cycle stalls the sweep rather than skipping an address.
                    we_d   = 1'b1;
                    addr_d = ptr_q[ADDR_WIDTH-1:0];
                    din_d  = is_water ? wcol_q : bcol_q;
                    ptr_d  = ptr_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SWEEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            level_q <= '0;
            wcol_q  <= '0;
            bcol_q  <= '0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            level_q <= level_d;
            wcol_q  <= wcol_d;
            bcol_q  <= bcol_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pw_gnt    = gnt_q;
    assign we        = we_q;
    assign addr_w    = addr_q;
    assign din       = din_q;
    assign busy      = busy_q;
    assign fill_done = done_q;
endmodule

// File: tb/tb_water_ram_ctrl.sv
// Self-checking bench for water_ram_ctrl: behavioural cycle model plus shadow RAMs.
module tb_water_ram_ctrl;
    localparam int AW = 10;
    localparam int DW = 2;
    localparam int CB = 5;
    localparam int LW = AW - CB + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic fill_start;
    logic [LW-1:0] fill_level;
    logic [DW-1:0] water_color, bg_color;
    logic pw_req;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;
    logic pw_gnt, we, busy, fill_done;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] din;

    water_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COL_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_level(fill_level),
        .water_color(water_color), .bg_color(bg_color), .pw_req(pw_req),
        .pw_addr(pw_addr), .pw_data(pw_data), .pw_gnt(pw_gnt), .we(we),
        .addr_w(addr_w), .din(din), .busy(busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 sweeping, 2 done cycle; m_cnt = sweep writes so far.
    int m_phase, m_cnt, m_level;
    logic [DW-1:0] m_wc, m_bc;
    logic m_g;
    logic e_gnt, e_we, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [DW-1:0] mram [1024];
    logic [DW-1:0] dram [1024];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_level = 0; m_wc = '0; m_bc = '0;
            e_gnt = 0; e_we = 0; e_busy = 0; e_done = 0; e_addr = '0; e_din = '0;
        end else begin
            m_g = pw_req && !e_gnt;
            e_gnt = m_g; e_we = 0; e_done = 0;
            if (m_g) begin
                e_we = 1; e_addr = pw_addr; e_din = pw_data; mram[pw_addr] = pw_data;
            end
            case (m_phase)
                0: if (fill_start) begin
                    m_level = (fill_level > 32) ? 32 : int'(fill_level);
                    m_wc = water_color; m_bc = bg_color; m_cnt = 0; m_phase = 1;
                end
                1: if (m_cnt == 1024) begin
                    m_phase = 2; e_done = 1;
                end else if (!m_g) begin
                    e_we = 1; e_addr = m_cnt[AW-1:0];
                    e_din = (m_cnt / 32 >= 32 - m_level) ? m_wc : m_bc;
                    mram[e_addr] = e_din;
                    m_cnt++;
                end
                default: m_phase = 0;
            endcase
            e_busy = (m_phase == 1);
        end
    end

    always @(posedge clk) if (rst_n && we) dram[addr_w] <= din;

    int sw_cnt, done_cnt, gnt_cnt;
    always @(negedge clk) begin
        chk("pw_gnt", pw_gnt, e_gnt);
        chk("we", we, e_we);
        chk("addr_w", addr_w, e_addr);
        chk("din", din, e_din);
        chk("busy", busy, e_busy);
        chk("fill_done", fill_done, e_done);
        if (busy && we) sw_cnt++;
        if (busy && pw_gnt) gnt_cnt++;
        if (fill_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic clr();
        sw_cnt = 0; done_cnt = 0; gnt_cnt = 0;
    endtask

    task automatic start_fill(input int lvl, input logic [DW-1:0] wc, input logic [DW-1:0] bc);
        fill_start = 1; fill_level = LW'(lvl); water_color = wc; bg_color = bc;
        step();
        fill_start = 0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (fill_done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        chk(nm, fill_done, 1);
    endtask

    task automatic wait_ptr(input int n);
        int k = 0;
        while (m_cnt < n && k < 3000) begin step(); k++; end
        chk("wait_ptr", (m_cnt >= n), 1);
    endtask

    task automatic ram_vs_model(input string nm);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (dram[i] !== mram[i]) bad++;
        chk(nm, bad, 0);
    endtask

    // Checks the RAM against a two-band picture: addresses >= split hold wc, below hold bc.
    task automatic ram_pattern(input string nm, input int split, input logic [DW-1:0] wc,
                               input logic [DW-1:0] bc);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (dram[i] !== ((i >= split) ? wc : bc)) bad++;
        chk(nm, bad, 0);
    endtask

    initial begin
        logic [AW-1:0] a_prev;
        int k, wec;
        for (int i = 0; i < 1024; i++) begin mram[i] = '0; dram[i] = '0; end
        fill_start = 0; fill_level = '0; water_color = '0; bg_color = '0;
        pw_req = 0; pw_addr = '0; pw_data = '0;
        rst_n = 0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        repeat (3) step();
        rst_n = 1;
        step();

        // Idle point write
        pw_req = 1; pw_addr = '0; pw_data = 2'b10;
        step();
        pw_req = 0;
        chk("idle_gnt", pw_gnt, 1);
        chk("idle_we", we, 1);
        chk("idle_addr", addr_w, 0);
        chk("idle_din", din, 2'b10);
        chk("idle_busy", busy, 0);
        step(); step();

        // Level 4 fill
        clr();
        start_fill(4, 2'b01, 2'b00);
        wait_done("l4_done");
        step();
        chk("l4_we_cycles", sw_cnt, 1024);
        chk("l4_done_cnt", done_cnt, 1);
        chk("l4_ram895", dram[895], 2'b00);
        chk("l4_ram896", dram[896], 2'b01);
        ram_pattern("l4_ram", 896, 2'b01, 2'b00);
        ram_vs_model("l4_model");

        // Extremes
        start_fill(0, 2'b01, 2'b11);
        wait_done("l0_done");
        step();
        ram_pattern("l0_ram", 1024, 2'b01, 2'b11);
        start_fill(40, 2'b10, 2'b00);
        wait_done("l40_done");
        step();
        ram_pattern("l40_ram", 0, 2'b10, 2'b00);

        // Arbitration: held request, grants every other cycle
        clr();
        start_fill(8, 2'b01, 2'b10);
        repeat (100) step();
        a_prev = addr_w;
        pw_req = 1; pw_addr = 10'h155; pw_data = 2'b11;
        step();
        chk("arb_gnt", pw_gnt, 1);
        chk("arb_addr", addr_w, 10'h155);
        chk("arb_din", din, 2'b11);
        step();
        chk("arb_nognt", pw_gnt, 0);
        chk("arb_stall", addr_w, a_prev + 10'd1);
        repeat (7) step();
        pw_req = 0;
        wait_done("arb_done");
        step();
        chk("arb_grants", gnt_cnt, 5);
        chk("arb_len", sw_cnt, 1029);
        ram_vs_model("arb_model");

        // Ignored starts mid-sweep and in the done cycle
        clr();
        start_fill(4, 2'b01, 2'b00);
        wait_ptr(500);
        fill_start = 1; fill_level = 6'd32; water_color = 2'b11; bg_color = 2'b11;
        step();
        fill_start = 0;
        wait_done("ign_done");
        fill_start = 1;
        step();
        fill_start = 0;
        repeat (5) step();
        chk("ign_busy", busy, 0);
        chk("ign_done_cnt", done_cnt, 1);
        ram_pattern("ign_ram", 896, 2'b01, 2'b00);

        // Randomized sweeps with random point writes and stray starts
        for (int r = 0; r < 3; r++) begin
            start_fill(int'($urandom_range(0, 40)), 2'($urandom), 2'($urandom));
            k = 0;
            while (k < 3000) begin
                step();
                if (fill_done) break;
                fill_start = ($urandom_range(0, 49) == 0);
                fill_level = 6'($urandom);
                if (!pw_req || pw_gnt) begin
                    pw_req = ($urandom_range(0, 3) == 0);
                    pw_addr = 10'($urandom);
                    pw_data = 2'($urandom);
                end
                k++;
            end
            chk("rnd_done", fill_done, 1);
            pw_req = 0; fill_start = 0;
            step(); step();
            ram_vs_model("rnd_model");
        end

        // Reset mid-sweep
        start_fill(4, 2'b01, 2'b00);
        wait_ptr(300);
        #1 rst_n = 0;
        #1;
        chk("mrst_we", we, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_addr", addr_w, 0);
        chk("mrst_din", din, 0);
        chk("mrst_gnt", pw_gnt, 0);
        chk("mrst_done", fill_done, 0);
        step(); step();
        rst_n = 1;
        wec = 0;
        repeat (20) begin step(); if (we) wec++; end
        chk("post_rst_no_we", wec, 0);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
